// File: rtl/ext_ddr4_arb_pkg.sv
// Shared types and the round-robin pick helper for the external DDR4 request arbiter.
package ext_ddr4_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // First eligible index after 'last', wrapping at n; -1 when nobody is eligible.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] eligible,
                                   input int last,
                                   input int n);
        int winner;
        int cand;
        winner = -1;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = last + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if (k <= n && winner < 0 &&
                (eligible & (MAX_REQ'(1) << cand)) != '0) begin
                winner = cand;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/ext_ddr4_rd_id_fifo.sv
// Requester-ID FIFO recording the issue order of reads so returned beats can be routed back.
module ext_ddr4_rd_id_fifo
    import ext_ddr4_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     core_clk_main_800mhz,
    input  logic                     core_reset_sync,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_id,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (wr_ptr == rd_ptr);
    assign pop_id  = mem[rd_ptr[AW-1:0]];

    // The extra pointer bit separates full from empty when the indices match.
    always_ff @(posedge core_clk_main_800mhz) begin
        if (core_reset_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk_main_800mhz) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_id;
        end
    end

endmodule

// File: rtl/ext_ddr4_req_arbiter.sv
// Round-robin arbiter sharing the external DDR4 command channel between core requesters,
// routing in-order read data back to the requester that issued each read.
module ext_ddr4_req_arbiter
    import ext_ddr4_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 512,
    parameter int RD_OUTSTANDING = 8
) (
    input  logic                              core_clk_main_800mhz,
    input  logic                              core_reset_sync,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]         req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]     req_wstrb,
    output logic                              ddr_cmd_valid,
    input  logic                              ddr_cmd_ready,
    output logic                              ddr_cmd_we,
    output logic [ADDR_W-1:0]                 ddr_cmd_addr,
    output logic [DATA_W-1:0]                 ddr_wdata,
    output logic [DATA_W/8-1:0]               ddr_wstrb,
    input  logic                              ddr_rd_valid,
    input  logic [DATA_W-1:0]                 ddr_rd_data,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic [$clog2(RD_OUTSTANDING):0]   rd_outstanding,
    output logic                              rsp_err,
    output logic                              arb_idle
);

    localparam int REQ_ID_W = $clog2(NUM_REQ);
    localparam int STRB_W   = DATA_W / 8;

    arb_state_t           state;
    logic [REQ_ID_W-1:0]  rr_ptr;
    logic [REQ_ID_W-1:0]  winner;
    logic [NUM_REQ-1:0]   eligible;
    int                   pick_idx;
    logic                 grant;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [REQ_ID_W-1:0]  fifo_head;

    // Reads need a free ID slot; writes never return data so they are always eligible.
    always_comb begin
        eligible  = req_valid & (req_write | {NUM_REQ{~fifo_full}});
        pick_idx  = rr_pick(MAX_REQ'(eligible), int'(rr_ptr), NUM_REQ);
        winner    = REQ_ID_W'(pick_idx);
        grant     = (state == IDLE) && (pick_idx >= 0) && !core_reset_sync;
        req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    end

    assign ddr_cmd_valid = (state == ISSUE);
    assign fifo_push     = (state == ISSUE) && ddr_cmd_ready && !ddr_cmd_we;
    assign fifo_pop      = ddr_rd_valid && !fifo_empty;
    assign arb_idle      = (state == IDLE) && (rd_outstanding == '0);

    // rr_ptr doubles as the ID of the held command, since it is updated to the winner on capture.
    always_ff @(posedge core_clk_main_800mhz) begin
        if (core_reset_sync) begin
            state        <= IDLE;
            rr_ptr       <= REQ_ID_W'(NUM_REQ - 1);
            ddr_cmd_we   <= 1'b0;
            ddr_cmd_addr <= '0;
            ddr_wdata    <= '0;
            ddr_wstrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        ddr_cmd_we   <= req_write[winner];
                        ddr_cmd_addr <= req_addr[winner*ADDR_W +: ADDR_W];
                        ddr_wdata    <= req_wdata[winner*DATA_W +: DATA_W];
                        ddr_wstrb    <= req_wstrb[winner*STRB_W +: STRB_W];
                        rr_ptr       <= winner;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ddr_cmd_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk_main_800mhz) begin
        if (core_reset_sync) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= fifo_pop ? (NUM_REQ'(1) << fifo_head) : '0;
            if (fifo_pop) begin
                rsp_data <= ddr_rd_data;
            end
            if (ddr_rd_valid && fifo_empty) begin
                rsp_err <= 1'b1;
            end
        end
    end

    ext_ddr4_rd_id_fifo #(
        .WIDTH (REQ_ID_W),
        .DEPTH (RD_OUTSTANDING)
    ) u_rd_id_fifo (
        .core_clk_main_800mhz (core_clk_main_800mhz),
        .core_reset_sync      (core_reset_sync),
        .push                 (fifo_push),
        .push_id              (rr_ptr),
        .pop                  (fifo_pop),
        .pop_id               (fifo_head),
        .full                 (fifo_full),
        .empty                (fifo_empty),
        .count                (rd_outstanding)
    );

endmodule

// File: tb/tb_ext_ddr4_req_arbiter.sv
// Bench for ext_ddr4_req_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model built from a pending-command record and an ID queue.
module tb_ext_ddr4_req_arbiter;

    localparam int NUM_REQ        = 3;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 512;
    localparam int STRB_W         = DATA_W / 8;
    localparam int RD_OUTSTANDING = 8;
    localparam int CNT_W          = $clog2(RD_OUTSTANDING) + 1;

    logic                       core_clk_main_800mhz = 1'b0;
    logic                       core_reset_sync;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata;
    logic [NUM_REQ*STRB_W-1:0]  req_wstrb;
    logic                       ddr_cmd_valid;
    logic                       ddr_cmd_ready;
    logic                       ddr_cmd_we;
    logic [ADDR_W-1:0]          ddr_cmd_addr;
    logic [DATA_W-1:0]          ddr_wdata;
    logic [STRB_W-1:0]          ddr_wstrb;
    logic                       ddr_rd_valid;
    logic [DATA_W-1:0]          ddr_rd_data;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]          rsp_data;
    logic [CNT_W-1:0]           rd_outstanding;
    logic                       rsp_err;
    logic                       arb_idle;

    always #5 core_clk_main_800mhz = ~core_clk_main_800mhz;

    ext_ddr4_req_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RD_OUTSTANDING (RD_OUTSTANDING)
    ) dut (
        .core_clk_main_800mhz (core_clk_main_800mhz),
        .core_reset_sync      (core_reset_sync),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .req_wstrb            (req_wstrb),
        .ddr_cmd_valid        (ddr_cmd_valid),
        .ddr_cmd_ready        (ddr_cmd_ready),
        .ddr_cmd_we           (ddr_cmd_we),
        .ddr_cmd_addr         (ddr_cmd_addr),
        .ddr_wdata            (ddr_wdata),
        .ddr_wstrb            (ddr_wstrb),
        .ddr_rd_valid         (ddr_rd_valid),
        .ddr_rd_data          (ddr_rd_data),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rd_outstanding       (rd_outstanding),
        .rsp_err              (rsp_err),
        .arb_idle             (arb_idle)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit                 m_known = 1'b0;
    bit                 m_pending;
    int                 m_id;
    bit                 m_we;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic [STRB_W-1:0]  m_wstrb;
    int                 m_last;
    int                 id_q[$];
    int                 m_rsp_id;
    logic [DATA_W-1:0]  m_rsp_data;
    bit                 m_err;
    int                 grant_log[$];

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) begin
            d[k*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    function automatic int pickWinner();
        int i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (m_last + k) % NUM_REQ;
            if (req_valid[i] && (req_write[i] || id_q.size() < RD_OUTSTANDING)) begin
                return i;
            end
        end
        return -1;
    endfunction

    // Checks the current outputs against the model, then advances the model and the DUT one clock.
    task automatic applyStimulus();
        int w;
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rsp;
        #1;
        w = (core_reset_sync || m_pending) ? -1 : pickWinner();
        if (m_known) begin
            exp_ready = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
            exp_rsp   = (m_rsp_id >= 0) ? (NUM_REQ'(1) << m_rsp_id) : '0;
            checkOutput("req_ready", DATA_W'(req_ready), DATA_W'(exp_ready));
            checkOutput("ddr_cmd_valid", DATA_W'(ddr_cmd_valid), DATA_W'(m_pending));
            if (m_pending) begin
                checkOutput("ddr_cmd_we", DATA_W'(ddr_cmd_we), DATA_W'(m_we));
                checkOutput("ddr_cmd_addr", DATA_W'(ddr_cmd_addr), DATA_W'(m_addr));
                checkOutput("ddr_wdata", ddr_wdata, m_wdata);
                checkOutput("ddr_wstrb", DATA_W'(ddr_wstrb), DATA_W'(m_wstrb));
            end
            checkOutput("rd_outstanding", DATA_W'(rd_outstanding), DATA_W'(id_q.size()));
            checkOutput("rsp_valid", DATA_W'(rsp_valid), DATA_W'(exp_rsp));
            checkOutput("rsp_data", rsp_data, m_rsp_data);
            checkOutput("rsp_err", DATA_W'(rsp_err), DATA_W'(m_err));
            checkOutput("arb_idle", DATA_W'(arb_idle),
                        DATA_W'(!m_pending && id_q.size() == 0));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_log.push_back(i);
            end
        end
        if (core_reset_sync) begin
            m_known    = 1'b1;
            m_pending  = 1'b0;
            m_last     = NUM_REQ - 1;
            id_q.delete();
            m_rsp_id   = -1;
            m_rsp_data = '0;
            m_err      = 1'b0;
        end else if (m_known) begin
            m_rsp_id = -1;
            if (ddr_rd_valid) begin
                if (id_q.size() > 0) begin
                    m_rsp_id   = id_q.pop_front();
                    m_rsp_data = ddr_rd_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_pending) begin
                if (ddr_cmd_ready) begin
                    if (!m_we) begin
                        id_q.push_back(m_id);
                    end
                    m_pending = 1'b0;
                end
            end else if (w >= 0) begin
                m_pending = 1'b1;
                m_id      = w;
                m_we      = req_write[w];
                m_addr    = req_addr[w*ADDR_W +: ADDR_W];
                m_wdata   = req_wdata[w*DATA_W +: DATA_W];
                m_wstrb   = req_wstrb[w*STRB_W +: STRB_W];
                m_last    = w;
            end
        end
        @(posedge core_clk_main_800mhz);
        #1;
    endtask

    task automatic setReq(input int i, input bit v, input bit we, input logic [ADDR_W-1:0] a);
        logic [STRB_W-1:0] s;
        s = {$urandom, $urandom};
        req_valid[i]                     = v;
        req_write[i]                     = we;
        req_addr[i*ADDR_W +: ADDR_W]     = a;
        req_wdata[i*DATA_W +: DATA_W]    = randData();
        req_wstrb[i*STRB_W +: STRB_W]    = s;
    endtask

    task automatic clearInputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            setReq(i, 1'b0, 1'b0, $urandom);
        end
        ddr_cmd_ready = 1'b0;
        ddr_rd_valid  = 1'b0;
        ddr_rd_data   = randData();
    endtask

    task automatic doReset();
        clearInputs();
        core_reset_sync = 1'b1;
        applyStimulus();
        applyStimulus();
        core_reset_sync = 1'b0;
    endtask

    initial begin
        int t1_exp[4] = '{0, 1, 2, 0};
        int t4_ord[3] = '{0, 2, 1};
        logic [DATA_W-1:0] t4_dat[3];
        t4_dat[0] = DATA_W'(32'hA);
        t4_dat[1] = DATA_W'(32'hB);
        t4_dat[2] = DATA_W'(32'hC);
        core_reset_sync = 1'b1;
        clearInputs();

        $display("[TB] scenario 1: round-robin reads");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1'b1, 1'b0, $urandom);
        ddr_cmd_ready = 1'b1;
        grant_log.delete();
        repeat (8) applyStimulus();
        checkOutput("t1_grant_count", DATA_W'(grant_log.size() >= 4), DATA_W'(1));
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) begin
                checkOutput("t1_grant_order", DATA_W'(grant_log[k]), DATA_W'(t1_exp[k]));
            end
        end

        $display("[TB] scenario 2: held write under backpressure");
        doReset();
        setReq(1, 1'b1, 1'b1, 32'h0000_1040);
        req_wstrb[1*STRB_W +: STRB_W] = '1;
        grant_log.delete();
        applyStimulus();
        repeat (5) applyStimulus();
        checkOutput("t2_addr_held", DATA_W'(ddr_cmd_addr), DATA_W'(32'h0000_1040));
        checkOutput("t2_wstrb_held", DATA_W'(ddr_wstrb), DATA_W'({STRB_W{1'b1}}));
        ddr_cmd_ready = 1'b1;
        req_valid     = '0;
        repeat (2) applyStimulus();
        checkOutput("t2_single_grant", DATA_W'(grant_log.size()), DATA_W'(1));
        checkOutput("t2_rd_outstanding", DATA_W'(rd_outstanding), DATA_W'(0));

        $display("[TB] scenario 3: full ID FIFO blocks reads only");
        doReset();
        setReq(2, 1'b1, 1'b0, $urandom);
        ddr_cmd_ready = 1'b1;
        for (int c = 0; c < 40 && id_q.size() < RD_OUTSTANDING; c++) applyStimulus();
        checkOutput("t3_filled", DATA_W'(rd_outstanding), DATA_W'(RD_OUTSTANDING));
        setReq(2, 1'b0, 1'b0, $urandom);
        setReq(0, 1'b1, 1'b0, 32'h0000_2000);
        setReq(1, 1'b1, 1'b1, 32'h0000_3000);
        grant_log.delete();
        repeat (2) applyStimulus();
        req_valid[1] = 1'b0;
        ddr_rd_valid = 1'b1;
        ddr_rd_data  = randData();
        applyStimulus();
        ddr_rd_valid = 1'b0;
        applyStimulus();
        req_valid[0] = 1'b0;
        applyStimulus();
        checkOutput("t3_grant_count", DATA_W'(grant_log.size()), DATA_W'(2));
        if (grant_log.size() == 2) begin
            checkOutput("t3_write_first", DATA_W'(grant_log[0]), DATA_W'(1));
            checkOutput("t3_read_after_pop", DATA_W'(grant_log[1]), DATA_W'(0));
        end
        checkOutput("t3_rd_outstanding", DATA_W'(rd_outstanding), DATA_W'(RD_OUTSTANDING));

        $display("[TB] scenario 4: in-order read data routing");
        doReset();
        ddr_cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setReq(t4_ord[k], 1'b1, 1'b0, $urandom);
            applyStimulus();
            req_valid = '0;
            applyStimulus();
        end
        for (int k = 0; k < 3; k++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = t4_dat[k];
            applyStimulus();
            checkOutput("t4_rsp_valid", DATA_W'(rsp_valid), DATA_W'(NUM_REQ'(1) << t4_ord[k]));
            checkOutput("t4_rsp_data", rsp_data, t4_dat[k]);
        end
        ddr_rd_valid = 1'b0;
        repeat (2) applyStimulus();

        $display("[TB] scenario 5: unexpected read beat");
        doReset();
        ddr_rd_valid = 1'b1;
        applyStimulus();
        ddr_rd_valid = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("t5_err_sticky", DATA_W'(rsp_err), DATA_W'(1));
        checkOutput("t5_no_rsp", DATA_W'(rsp_valid), DATA_W'(0));
        doReset();
        checkOutput("t5_err_cleared", DATA_W'(rsp_err), DATA_W'(0));

        $display("[TB] scenario 6: reset during ISSUE");
        doReset();
        ddr_cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setReq(k, 1'b1, 1'b0, $urandom);
            applyStimulus();
            req_valid = '0;
            applyStimulus();
        end
        ddr_cmd_ready = 1'b0;
        setReq(1, 1'b1, 1'b0, $urandom);
        applyStimulus();
        checkOutput("t6_in_issue", DATA_W'(ddr_cmd_valid), DATA_W'(1));
        core_reset_sync = 1'b1;
        applyStimulus();
        core_reset_sync = 1'b0;
        checkOutput("t6_cmd_valid", DATA_W'(ddr_cmd_valid), DATA_W'(0));
        checkOutput("t6_rd_outstanding", DATA_W'(rd_outstanding), DATA_W'(0));
        checkOutput("t6_arb_idle", DATA_W'(arb_idle), DATA_W'(1));
        req_valid     = '1;
        ddr_cmd_ready = 1'b1;
        grant_log.delete();
        applyStimulus();
        checkOutput("t6_first_grant", DATA_W'(grant_log.size() > 0 ? grant_log[0] : -1), DATA_W'(0));

        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 3000; c++) begin
            core_reset_sync = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                setReq(i, 1'($urandom), 1'($urandom), $urandom);
            end
            ddr_cmd_ready = ($urandom_range(0, 2) != 0);
            ddr_rd_valid  = (id_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 49) == 0);
            ddr_rd_data   = randData();
            applyStimulus();
        end
        core_reset_sync = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
